// File: rtl/cpu_pkg.sv
// cpu_pkg: register-file geometry and word types shared by the CPU datapath
// blocks (operand fetch, register file, scoreboard).
// Optional feature macro used by the blocks importing this package: WB_BYPASS_EN.
package cpu_pkg;

  localparam int REG_AW   = 5;
  localparam int NUM_REGS = 32;
  localparam int DATA_W   = 32;

  typedef logic [REG_AW-1:0]   reg_addr_t;
  typedef logic [DATA_W-1:0]   word_t;
  typedef logic [NUM_REGS-1:0] reg_mask_t;

  // One-hot mask selecting a single architectural register.
  function automatic reg_mask_t reg_onehot(input reg_addr_t addr);
    reg_mask_t mask;
    mask       = {NUM_REGS{1'b0}};
    mask[addr] = 1'b1;
    return mask;
  endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// reg_scoreboard: one busy bit per architectural register, set when an
// instruction writing that register issues and cleared by the writeback bus.
// Provides three hazard lookups (two sources, one destination).
// Feature macro: WB_BYPASS_EN -- when defined, a register being written back
// this cycle already reads as not busy in the lookups.
module reg_scoreboard
  import cpu_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_set_en,
  input  logic [REG_AW-1:0]   i_set_addr,
  input  logic                i_clr_en,
  input  logic [REG_AW-1:0]   i_clr_addr,
  input  logic [REG_AW-1:0]   i_look0,
  input  logic [REG_AW-1:0]   i_look1,
  input  logic [REG_AW-1:0]   i_look2,
  output logic [NUM_REGS-1:0] o_busy,
  output logic                o_hit0,
  output logic                o_hit1,
  output logic                o_hit2
);

  reg_mask_t r_busy;
  reg_mask_t w_set;
  reg_mask_t w_clr;
  reg_mask_t w_busy_eff;

  // Decode the set and clear strobes into register masks.
  always_comb begin
    w_set = {NUM_REGS{1'b0}};
    w_clr = {NUM_REGS{1'b0}};
    if (i_set_en) begin
      w_set = reg_onehot(i_set_addr);
    end else begin
      w_set = {NUM_REGS{1'b0}};
    end
    if (i_clr_en) begin
      w_clr = reg_onehot(i_clr_addr);
    end else begin
      w_clr = {NUM_REGS{1'b0}};
    end
  end

`ifdef WB_BYPASS_EN
  // The write in flight this cycle is forwarded, so its register is free now.
  assign w_busy_eff = r_busy & ~w_clr;
`else
  // Operands only come from the register file, so wait until it holds the value.
  assign w_busy_eff = r_busy;
`endif

  assign o_hit0 = w_busy_eff[i_look0];
  assign o_hit1 = w_busy_eff[i_look1];
  assign o_hit2 = w_busy_eff[i_look2];
  assign o_busy = r_busy;

  // Busy vector update: clear first, then set, so a same-address set survives.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_busy <= {NUM_REGS{1'b0}};
    end else begin
      r_busy <= (r_busy & ~w_clr) | w_set;
    end
  end

endmodule

// File: rtl/operand_fetch.sv
// operand_fetch: decode->execute operand-fetch stage. Reads both source
// operands from the register file, stalls on RAW/WAW hazards tracked by a
// busy scoreboard, and registers operands plus payload toward execute.
// Feature macro: WB_BYPASS_EN -- when defined, the writeback bus is forwarded
// into the operands and a dependent instruction may issue in the writeback
// cycle; when undefined, operands always come from the register file.
module operand_fetch
  import cpu_pkg::*;
#(
  parameter int OP_W = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [REG_AW-1:0]   in_rs0,
  input  logic [REG_AW-1:0]   in_rs1,
  input  logic [REG_AW-1:0]   in_rd,
  input  logic                in_rd_we,
  input  logic [OP_W-1:0]     in_op,
  output logic [REG_AW-1:0]   rf_raddr0,
  output logic [REG_AW-1:0]   rf_raddr1,
  input  logic [DATA_W-1:0]   rf_rdata0,
  input  logic [DATA_W-1:0]   rf_rdata1,
  input  logic                wb_valid,
  input  logic [REG_AW-1:0]   wb_addr,
  input  logic [DATA_W-1:0]   wb_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DATA_W-1:0]   out_opa,
  output logic [DATA_W-1:0]   out_opb,
  output logic [REG_AW-1:0]   out_rd,
  output logic                out_rd_we,
  output logic [OP_W-1:0]     out_op,
  output logic [NUM_REGS-1:0] busy
);

  logic      r_out_valid;
  word_t     r_out_opa;
  word_t     r_out_opb;
  reg_addr_t r_out_rd;
  logic      r_out_rd_we;
  logic [OP_W-1:0] r_out_op;

  logic  w_hit_rs0;
  logic  w_hit_rs1;
  logic  w_hit_rd;
  logic  w_hazard;
  logic  w_slot_free;
  logic  w_accept;
  word_t w_opa;
  word_t w_opb;

  // Register file reads follow the incoming source fields directly.
  assign rf_raddr0 = in_rs0;
  assign rf_raddr1 = in_rs1;

  reg_scoreboard u_scoreboard (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_set_en   (w_accept & in_rd_we),
    .i_set_addr (in_rd),
    .i_clr_en   (wb_valid),
    .i_clr_addr (wb_addr),
    .i_look0    (in_rs0),
    .i_look1    (in_rs1),
    .i_look2    (in_rd),
    .o_busy     (busy),
    .o_hit0     (w_hit_rs0),
    .o_hit1     (w_hit_rs1),
    .o_hit2     (w_hit_rd)
  );

  // The destination only matters for WAW when the instruction actually writes it.
  assign w_hazard    = w_hit_rs0 | w_hit_rs1 | (in_rd_we & w_hit_rd);
  assign w_slot_free = ~r_out_valid | out_ready;
  assign in_ready    = w_slot_free & ~w_hazard;
  assign w_accept    = in_valid & in_ready;

`ifdef WB_BYPASS_EN
  // Forward the writeback value into any source that names the register being written.
  always_comb begin
    w_opa = rf_rdata0;
    w_opb = rf_rdata1;
    if (wb_valid && (wb_addr == in_rs0)) begin
      w_opa = wb_data;
    end else begin
      w_opa = rf_rdata0;
    end
    if (wb_valid && (wb_addr == in_rs1)) begin
      w_opb = wb_data;
    end else begin
      w_opb = rf_rdata1;
    end
  end
`else
  logic w_unused_wb_data;

  // Without forwarding the operands are exactly what the register file returns.
  always_comb begin
    w_opa = rf_rdata0;
    w_opb = rf_rdata1;
  end

  assign w_unused_wb_data = ^wb_data;
`endif

  // Decode/execute pipeline register: load on accept, drop valid once drained.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_opa   <= {DATA_W{1'b0}};
      r_out_opb   <= {DATA_W{1'b0}};
      r_out_rd    <= {REG_AW{1'b0}};
      r_out_rd_we <= 1'b0;
      r_out_op    <= {OP_W{1'b0}};
    end else if (w_accept) begin
      r_out_valid <= 1'b1;
      r_out_opa   <= w_opa;
      r_out_opb   <= w_opb;
      r_out_rd    <= in_rd;
      r_out_rd_we <= in_rd_we;
      r_out_op    <= in_op;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= r_out_valid;
    end
  end

  assign out_valid = r_out_valid;
  assign out_opa   = r_out_opa;
  assign out_opb   = r_out_opb;
  assign out_rd    = r_out_rd;
  assign out_rd_we = r_out_rd_we;
  assign out_op    = r_out_op;

endmodule

// File: tb/tb_operand_fetch.sv
// tb_operand_fetch: self-checking bench for operand_fetch. A bench-side
// register file, busy model and expected-output queue run in lock-step with
// the DUT; builds with and without WB_BYPASS_EN are both handled.
module tb_operand_fetch;

  localparam int OP_W = 16;

  typedef struct packed {
    logic [31:0]     opa;
    logic [31:0]     opb;
    logic [4:0]      rd;
    logic            we;
    logic [OP_W-1:0] op;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            in_valid;
  logic            in_ready;
  logic [4:0]      in_rs0;
  logic [4:0]      in_rs1;
  logic [4:0]      in_rd;
  logic            in_rd_we;
  logic [OP_W-1:0] in_op;
  logic [4:0]      rf_raddr0;
  logic [4:0]      rf_raddr1;
  logic [31:0]     rf_rdata0;
  logic [31:0]     rf_rdata1;
  logic            wb_valid;
  logic [4:0]      wb_addr;
  logic [31:0]     wb_data;
  logic            out_valid;
  logic            out_ready;
  logic [31:0]     out_opa;
  logic [31:0]     out_opb;
  logic [4:0]      out_rd;
  logic            out_rd_we;
  logic [OP_W-1:0] out_op;
  logic [31:0]     busy;

  logic [31:0] rf [32];
  exp_t        exp_q [$];
  exp_t        m_last;
  logic [31:0] m_busy;
  logic        m_out_valid;
  logic        m_known;
  logic        last_acc;
  int          n_checks;
  int          n_fail;

  always #5 clk = ~clk;

  assign rf_rdata0 = rf[rf_raddr0];
  assign rf_rdata1 = rf[rf_raddr1];

  operand_fetch #(.OP_W(OP_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_rs0(in_rs0), .in_rs1(in_rs1), .in_rd(in_rd), .in_rd_we(in_rd_we), .in_op(in_op),
    .rf_raddr0(rf_raddr0), .rf_raddr1(rf_raddr1), .rf_rdata0(rf_rdata0), .rf_rdata1(rf_rdata1),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_opa(out_opa), .out_opb(out_opb), .out_rd(out_rd), .out_rd_we(out_rd_we), .out_op(out_op),
    .busy(busy)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic drive(input logic v, input logic [4:0] a, input logic [4:0] b,
                       input logic [4:0] d, input logic w, input logic [OP_W-1:0] op);
    in_valid = v; in_rs0 = a; in_rs1 = b; in_rd = d; in_rd_we = w; in_op = op;
  endtask

  // One clock: check DUT against the model, push an expectation on accept,
  // advance the model at the edge, then commit the writeback into the bench RF.
  task automatic step();
    exp_t        disp;
    exp_t        e;
    logic [31:0] mclr;
    logic [31:0] mbe;
    logic        haz;
    logic        exp_rdy;
    logic        pw_v;
    logic [4:0]  pw_addr;
    logic [31:0] pw_data;
    #1;
    last_acc = 1'b0;
    mclr = wb_valid ? (32'h1 << wb_addr) : 32'h0;
    if (m_known) begin
      check_eq("rf_raddr0", rf_raddr0, in_rs0);
      check_eq("rf_raddr1", rf_raddr1, in_rs1);
      if (m_out_valid) check_eq("sb_depth", exp_q.size(), 1);
      disp = (exp_q.size() > 0) ? exp_q[0] : m_last;
      check_eq("out_valid", out_valid, m_out_valid);
      check_eq("out_opa", out_opa, disp.opa);
      check_eq("out_opb", out_opb, disp.opb);
      check_eq("out_rd", out_rd, disp.rd);
      check_eq("out_rd_we", out_rd_we, disp.we);
      check_eq("out_op", out_op, disp.op);
      check_eq("busy", busy, m_busy);
`ifdef WB_BYPASS_EN
      mbe = m_busy & ~mclr;
`else
      mbe = m_busy;
`endif
      haz = mbe[in_rs0] | mbe[in_rs1] | (in_rd_we & mbe[in_rd]);
      exp_rdy = (!m_out_valid || out_ready) && !haz;
      check_eq("in_ready", in_ready, exp_rdy);
      if (rst_n && in_valid && exp_rdy) begin
        last_acc = 1'b1;
        e.opa = rf[in_rs0];
        e.opb = rf[in_rs1];
`ifdef WB_BYPASS_EN
        if (wb_valid && wb_addr == in_rs0) e.opa = wb_data;
        if (wb_valid && wb_addr == in_rs1) e.opb = wb_data;
`endif
        e.rd = in_rd; e.we = in_rd_we; e.op = in_op;
        exp_q.push_back(e);
      end
    end
    pw_v = wb_valid; pw_addr = wb_addr; pw_data = wb_data;
    @(posedge clk);
    if (!rst_n) begin
      m_busy = 32'h0; m_out_valid = 1'b0; m_last = '0; exp_q.delete(); m_known = 1'b1;
    end else if (m_known) begin
      if (m_out_valid && out_ready && exp_q.size() > 0) m_last = exp_q.pop_front();
      if (last_acc) m_out_valid = 1'b1;
      else if (out_ready) m_out_valid = 1'b0;
      m_busy = (m_busy & ~mclr) | ((last_acc && in_rd_we) ? (32'h1 << in_rd) : 32'h0);
    end
    @(negedge clk);
    if (pw_v) rf[pw_addr] = pw_data;
  endtask

  // Present an instruction and hold it until accepted or the budget runs out.
  task automatic send(input logic [4:0] a, input logic [4:0] b, input logic [4:0] d,
                      input logic w, input logic [OP_W-1:0] op);
    logic done;
    done = 1'b0;
    drive(1'b1, a, b, d, w, op);
    for (int k = 0; k < 20 && !done; k++) begin
      step();
      done = last_acc;
    end
    check_eq("send_accepted", done, 1'b1);
    in_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks = 0; n_fail = 0;
    m_known = 1'b0; m_busy = 32'h0; m_out_valid = 1'b0; m_last = '0; last_acc = 1'b0;
    for (int i = 0; i < 32; i++) rf[i] = 32'h100 + i;
    rf[1] = 32'h11; rf[2] = 32'h22;
    rst_n = 1'b0; out_ready = 1'b1;
    wb_valid = 1'b0; wb_addr = 5'd0; wb_data = 32'h0;
    drive(1'b1, 5'd1, 5'd2, 5'd3, 1'b1, 16'hA001);
    @(negedge clk);

    // Reset held two cycles with a valid instruction waiting.
    step(); step();
    check_eq("rst_busy", busy, 32'h0);
    check_eq("rst_out_valid", out_valid, 1'b0);

    // Release: independent instruction issues immediately.
    rst_n = 1'b1;
    step();
    check_eq("indep_acc", last_acc, 1'b1);
    drive(1'b1, 5'd3, 5'd2, 5'd4, 1'b1, 16'hA002);
    check_eq("indep_opa", out_opa, 32'h11);
    check_eq("indep_opb", out_opb, 32'h22);
    check_eq("indep_rd", out_rd, 5'd3);
    check_eq("indep_busy3", busy[3], 1'b1);

    // RAW on r3: stalls until the writeback of 0xAB.
    for (int i = 0; i < 3; i++) begin
      step();
      check_eq("raw_stall", last_acc, 1'b0);
    end
    wb_valid = 1'b1; wb_addr = 5'd3; wb_data = 32'hAB;
    step();
`ifdef WB_BYPASS_EN
    check_eq("raw_wb_acc", last_acc, 1'b1);
`else
    check_eq("raw_wb_acc", last_acc, 1'b0);
`endif
    wb_valid = 1'b0;
    if (!last_acc) begin
      step();
      check_eq("raw_late_acc", last_acc, 1'b1);
    end
    in_valid = 1'b0;
    check_eq("raw_opa", out_opa, 32'hAB);
    check_eq("raw_busy3", busy[3], 1'b0);

    // Backpressure: output held three cycles, queued instruction waits.
    out_ready = 1'b0;
    drive(1'b1, 5'd1, 5'd2, 5'd6, 1'b1, 16'hA003);
    for (int i = 0; i < 3; i++) begin
      step();
      check_eq("bp_stall", last_acc, 1'b0);
      check_eq("bp_hold_opa", out_opa, 32'hAB);
    end
    out_ready = 1'b1;
    step();
    check_eq("bp_release_acc", last_acc, 1'b1);
    in_valid = 1'b0;

    // Full throughput: four independent instructions back to back.
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 5'(7 + i), 5'(8 + i), 5'(20 + i), 1'b1, 16'($urandom));
      step();
      check_eq("thru_acc", last_acc, 1'b1);
    end
    in_valid = 1'b0;
    step();

    // Set/clear collision on r5.
    send(5'd1, 5'd2, 5'd5, 1'b1, 16'hA005);
    drive(1'b1, 5'd1, 5'd2, 5'd5, 1'b1, 16'hA006);
    wb_valid = 1'b1; wb_addr = 5'd5; wb_data = 32'h55;
    step();
`ifdef WB_BYPASS_EN
    check_eq("waw_wb_acc", last_acc, 1'b1);
`else
    check_eq("waw_wb_acc", last_acc, 1'b0);
`endif
    wb_valid = 1'b0;
    if (!last_acc) begin
      step();
      check_eq("waw_late_acc", last_acc, 1'b1);
    end
    in_valid = 1'b0;
    check_eq("waw_busy5", busy[5], 1'b1);
    step();

    // Mid-operation reset with pending r3/r5 and a held output.
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    send(5'd1, 5'd2, 5'd3, 1'b1, 16'hB001);
    send(5'd1, 5'd2, 5'd5, 1'b1, 16'hB002);
    out_ready = 1'b0;
    check_eq("mid_busy_pre", busy, 32'h0000_0028);
    check_eq("mid_valid_pre", out_valid, 1'b1);
    step();
    rst_n = 1'b0;
    step();
    check_eq("mid_busy", busy, 32'h0);
    check_eq("mid_out_valid", out_valid, 1'b0);
    check_eq("mid_out_opa", out_opa, 32'h0);
    check_eq("mid_out_rd", out_rd, 5'd0);
    check_eq("mid_out_op", out_op, 16'h0);
    rst_n = 1'b1;
    out_ready = 1'b1;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
